// File: rtl/apb_timer_irq_pkg.sv
// Package for the timer interrupt controller.
// Holds the APB register word indices and the request FSM state type.
package apb_timer_irq_pkg;

  // APB word indices, taken from PADDR[4:2]
  localparam logic [2:0] REG_MASK     = 3'd0;
  localparam logic [2:0] REG_TRIG     = 3'd1;
  localparam logic [2:0] REG_PENDING  = 3'd2;
  localparam logic [2:0] REG_PEND_SET = 3'd3;
  localparam logic [2:0] REG_PEND_CLR = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;
  localparam logic [2:0] REG_ID       = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder.
// Ports:
//   in_i    [NUM_SRC]  request vector
//   valid_o            any bit of in_i set
//   idx_o   [IDW]      index of the lowest set bit (0 when none set)
module irq_prio_enc #(
  parameter  int unsigned NUM_SRC = 8,
  localparam int unsigned IDW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] in_i,
  output logic               valid_o,
  output logic [IDW-1:0]     idx_o
);

  logic found;

  always_comb begin
    valid_o = |in_i;
    idx_o   = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (in_i[i] && !found) begin
        idx_o = IDW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_timer_irq_ctrl.sv
// Interrupt controller for the APB timer event lines.
// Captures per-source events into PENDING (edge or level mode per source),
// masks them, and presents one registered request at a time to the core
// with an ack handshake. Software controls it through an APB slave.
// Ports:
//   HCLK, HRESETn           clock, asynchronous active-low reset
//   PADDR..PENABLE          APB request (word index PADDR[4:2])
//   PRDATA/PREADY/PSLVERR   APB response (no wait states, never errors)
//   event_i   [NUM_SRC]     timer interrupt lines, synchronous to HCLK
//   irq_o                   request to core, registered
//   irq_id_o  [IDW]         source index of the current request
//   irq_ack_i               core accepts the request (1-cycle pulse)
module apb_timer_irq_ctrl
  import apb_timer_irq_pkg::*;
#(
  parameter  int unsigned APB_ADDR_WIDTH = 12,
  parameter  int unsigned NUM_SRC        = 8,
  localparam int unsigned IDW            = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_SRC-1:0]        event_i,
  output logic                      irq_o,
  output logic [IDW-1:0]            irq_id_o,
  input  logic                      irq_ack_i
);

  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] trig_q, trig_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] event_q;
  irq_state_e         state_q, state_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               irq_q, irq_d;

  logic               wr_en, rd_en;
  logic [2:0]         reg_idx;
  logic [NUM_SRC-1:0] wdata;
  logic [NUM_SRC-1:0] status;
  logic [NUM_SRC-1:0] set_hw, set_sw, clr_sw, clr_ack;
  logic               enc_valid;
  logic [IDW-1:0]     enc_idx;
  logic               unused_ok;

  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign unused_ok = ^{PADDR, PWDATA};

  assign wr_en   = PSEL & PENABLE & PWRITE;
  assign rd_en   = PSEL & PENABLE & ~PWRITE;
  assign reg_idx = PADDR[4:2];
  assign wdata   = PWDATA[NUM_SRC-1:0];
  assign status  = pend_q & mask_q;

  // Level sources re-set every cycle the line is high; edge sources only on 0->1.
  assign set_hw = event_i & (trig_q | ~event_q);

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio (
    .in_i    (status),
    .valid_o (enc_valid),
    .idx_o   (enc_idx)
  );

  // APB register writes
  always_comb begin
    mask_d = mask_q;
    trig_d = trig_q;
    set_sw = '0;
    clr_sw = '0;
    if (wr_en) begin
      case (reg_idx)
        REG_MASK:     mask_d = wdata;
        REG_TRIG:     trig_d = wdata;
        REG_PEND_SET: set_sw = wdata;
        REG_PEND_CLR: clr_sw = wdata;
        default:      ;
      endcase
    end
  end

  // APB read mux; idle bus returns zero
  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (reg_idx)
        REG_MASK:    PRDATA = 32'(mask_q);
        REG_TRIG:    PRDATA = 32'(trig_q);
        REG_PENDING: PRDATA = 32'(pend_q);
        REG_STATUS:  PRDATA = 32'(status);
        REG_ID:      PRDATA = {enc_valid, 31'(enc_idx)};
        default:     PRDATA = '0;
      endcase
    end
  end

  // Request FSM. id_q is only reloaded in IDLE, so it cannot change under irq_o.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr_ack = '0;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          id_d    = enc_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          clr_ack = NUM_SRC'(1) << id_q;
          state_d = GAP;
        end else if (!status[id_q]) begin
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Set terms are ORed last so a same-cycle set beats any clear.
  assign pend_d = (pend_q & ~(clr_sw | clr_ack)) | set_hw | set_sw;
  assign irq_d  = (state_d == REQ);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mask_q  <= '0;
      trig_q  <= '0;
      pend_q  <= '0;
      event_q <= '0;
      state_q <= IDLE;
      id_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      trig_q  <= trig_d;
      pend_q  <= pend_d;
      event_q <= event_i;
      state_q <= state_d;
      id_q    <= id_d;
      irq_q   <= irq_d;
    end
  end

  assign irq_o    = irq_q;
  assign irq_id_o = id_q;

endmodule

// File: tb/tb_apb_timer_irq_ctrl.sv
// Self-checking bench for apb_timer_irq_ctrl: directed scenarios followed by
// randomized APB/event/ack traffic, checked against a behavioural model
// through an expectation queue drained by a separate monitor.
module tb_apb_timer_irq_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [7:0]  event_i = '0;
  logic        irq_o;
  logic [2:0]  irq_id_o;
  logic        irq_ack_i = 1'b0;

  apb_timer_irq_ctrl #(
    .APB_ADDR_WIDTH (12),
    .NUM_SRC        (8)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .event_i   (event_i),
    .irq_o     (irq_o),
    .irq_id_o  (irq_id_o),
    .irq_ack_i (irq_ack_i)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          irq;
    int          id;
    logic [31:0] prd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  // Reference model: per-source bit arrays plus "who is being requested" and
  // a cool-down counting the cycles before arbitration may run again.
  bit [7:0] m_mask, m_trig, m_pend, m_prev;
  bit       m_req;
  int       m_id;
  int       m_cool;
  bit [7:0] ev_r = '0;
  bit       ack_r = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mask = '0; m_trig = '0; m_pend = '0; m_prev = '0;
    m_req = 0; m_id = 0; m_cool = 0;
  endtask

  // One clock cycle: drive inputs, queue what the DUT must show this cycle,
  // advance the model across the coming edge.
  task automatic step(input bit sel, input bit en, input bit wr, input int idx, input logic [31:0] wd);
    bit [7:0]    st, set, clr, n_mask, n_trig;
    logic [31:0] rexp;
    int          lo;
    exp_t        e;
    PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = 12'(idx << 2); PWDATA = wd;
    event_i = ev_r; irq_ack_i = ack_r;
    st = m_pend & m_mask;
    rexp = '0;
    if (sel && en && !wr) begin
      case (idx)
        0: rexp = 32'(m_mask);
        1: rexp = 32'(m_trig);
        2: rexp = 32'(m_pend);
        5: rexp = 32'(st);
        6: begin
          lo = lowest(st);
          rexp = (lo < 0) ? 32'h0 : (32'h8000_0000 | 32'(lo));
        end
        default: rexp = '0;
      endcase
    end
    e.irq = m_req; e.id = m_id; e.prd = rexp;
    exp_q.push_back(e);

    set = '0; clr = '0; n_mask = m_mask; n_trig = m_trig;
    for (int i = 0; i < 8; i++)
      if (ev_r[i] && (m_trig[i] || !m_prev[i])) set[i] = 1;
    if (sel && en && wr) begin
      case (idx)
        0: n_mask = wd[7:0];
        1: n_trig = wd[7:0];
        3: set = set | wd[7:0];
        4: clr = clr | wd[7:0];
        default: ;
      endcase
    end
    if (m_req) begin
      if (ack_r) begin clr[m_id] = 1; m_req = 0; m_cool = 1; end
      else if (!st[m_id]) begin m_req = 0; m_cool = 1; end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      lo = lowest(st);
      if (lo >= 0) begin m_req = 1; m_id = lo; end
    end
    m_pend = (m_pend & ~clr) | set;
    m_prev = ev_r; m_mask = n_mask; m_trig = n_trig;
    @(posedge HCLK); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0);
  endtask

  task automatic apb_write(input int idx, input logic [31:0] d);
    step(1, 0, 1, idx, d);
    step(1, 1, 1, idx, d);
  endtask

  task automatic apb_read(input int idx);
    step(1, 0, 0, idx, '0);
    step(1, 1, 0, idx, '0);
  endtask

  task automatic wait_req(input int budget);
    ack_r = 0;
    for (int i = 0; i < budget && !m_req; i++) step(0, 0, 0, 0, '0);
    check("req_within_budget", 32'(m_req), 32'd1);
  endtask

  task automatic ack_once();
    ack_r = 1; step(0, 0, 0, 0, '0); ack_r = 0;
  endtask

  // Monitor: compares every queued expectation at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("irq_o", 32'(irq_o), 32'(e.irq));
        check("irq_id_o", 32'(irq_id_o), 32'(e.id));
        check("prdata", PRDATA, e.prd);
      end
      if (done && exp_q.size() == 0) break;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int k;
    bit ph = 0;
    bit cwr;
    int cidx;
    logic [31:0] cdat;
    model_reset();
    #23 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    check("reset_irq", 32'(irq_o), 32'd0);
    check("reset_id", 32'(irq_id_o), 32'd0);
    apb_read(0); apb_read(2);

    // single edge source, ack, no re-request while line stays high
    apb_write(0, 32'h3);
    ev_r = 8'h02; wait_req(6);
    idle(2); ack_once(); idle(4); apb_read(2);

    // simultaneous edges: src 0 first, then src 5; ID register checked
    ev_r = '0; apb_write(0, 32'hFFFF_FFFF);
    ev_r = 8'h21; wait_req(6); ack_once();
    wait_req(6); apb_read(6); apb_read(5); ack_once(); idle(3);

    // edge held high once; then level mode re-request after ack
    ev_r = 8'h04; wait_req(6); ack_once(); idle(20);
    apb_write(1, 32'h4); wait_req(6); ack_once(); wait_req(6);
    ev_r = '0; apb_write(4, 32'h4); idle(3); apb_write(1, 32'h0);

    // withdraw by PEND_CLR, then by masking
    ev_r = 8'h08; wait_req(6); apb_write(4, 32'h8); idle(3);
    ev_r = '0; idle(1); ev_r = 8'h08; wait_req(6);
    apb_write(0, 32'hF7); idle(3); apb_read(2);

    // new edge on id_q in ack cycle, PEND_SET, unmapped offset
    apb_write(4, 32'hFF); apb_write(0, 32'hFF); ev_r = '0; idle(2);
    ev_r = 8'h40; wait_req(6); ev_r = '0; idle(1);
    ev_r = 8'h40; ack_once(); wait_req(6); ack_once(); idle(2);
    apb_write(3, 32'h10); wait_req(6); apb_read(7); apb_write(7, 32'hFFFF_FFFF); apb_read(7);
    ack_once(); idle(3);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 7);
        ev_r[k] = ~ev_r[k];
      end
      ack_r = m_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      if (ph) begin
        step(1, 1, cwr, cidx, cdat);
        ph = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        cwr = 1'($urandom_range(0, 1));
        cidx = $urandom_range(0, 7);
        cdat = $urandom;
        step(1, 0, cwr, cidx, cdat);
        ph = 1;
      end else begin
        step(0, 0, 0, $urandom_range(0, 7), $urandom);
      end
    end
    ack_r = 0;

    // asynchronous reset in the middle of a request
    ev_r = '0; apb_write(1, 32'h0); apb_write(0, 32'hFF); apb_write(3, 32'h4);
    wait_req(8);
    #1 HRESETn = 1'b0;
    #1 check("async_rst_irq", 32'(irq_o), 32'd0);
    check("async_rst_id", 32'(irq_id_o), 32'd0);
    PSEL = 1; PENABLE = 1; PWRITE = 0; PADDR = 12'h000;
    #1 check("async_rst_mask", PRDATA, 32'h0);
    PADDR = 12'h008;
    #1 check("async_rst_pend", PRDATA, 32'h0);
    PSEL = 0; PENABLE = 0; event_i = '0; irq_ack_i = 0;
    model_reset();
    @(negedge HCLK); @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // clean resume after reset
    apb_read(0);
    apb_write(0, 32'h80);
    ev_r = 8'h80; wait_req(6); ack_once(); idle(4); apb_read(2);
    done = 1;
  end

endmodule
